// File: rtl/ammo_controller.sv
// ammo_controller
// ---------------------------------------------------------------------------
// Ammunition manager feeding the bullet HUD renderer. Converts the fire and
// reload button levels into single-shot events, produces a one-cycle
// projectile-spawn pulse, enforces a per-shot cooldown and runs a timed,
// round-by-round reload. All timing is counted in video frames using the
// one-cycle frame tick from the VGA timing generator.
//
// Parameters:
//   MAX_AMMO         magazine size and reset value of count (1..7)
//   COOLDOWN_FRAMES  frames between a shot and the next accepted shot (>=1)
//   RELOAD_FRAMES    frames per round restored during reload (>=1)
//
// Ports:
//   clk         in   system clock, the only clock
//   rst         in   synchronous active-high reset
//   frame_tick  in   one-cycle pulse once per frame
//   fire_btn    in   fire button level (synchronized, debounced)
//   reload_btn  in   reload button level (synchronized, debounced)
//   count       out  rounds in the magazine, 0..MAX_AMMO (registered)
//   fire        out  one-cycle projectile-spawn pulse (registered)
//   reloading   out  high while reloading (registered)
// ---------------------------------------------------------------------------
module ammo_controller #(
  parameter int MAX_AMMO        = 5,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int RELOAD_FRAMES   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       fire_btn,
  input  logic       reload_btn,
  output logic [2:0] count,
  output logic       fire,
  output logic       reloading
);

  localparam int MAX_FRAMES = (COOLDOWN_FRAMES > RELOAD_FRAMES) ? COOLDOWN_FRAMES : RELOAD_FRAMES;
  localparam int TW         = $clog2(MAX_FRAMES + 1);

  localparam logic [2:0]    MAX_C  = 3'(MAX_AMMO);
  localparam logic [TW-1:0] COOL_T = TW'(COOLDOWN_FRAMES);
  localparam logic [TW-1:0] REL_T  = TW'(RELOAD_FRAMES);
  localparam logic [TW-1:0] ONE_T  = TW'(1);

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_RELOAD   = 2'd2
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_count;
  logic          r_fire;
  logic          r_reloading;
  logic          r_fire_q;
  logic          r_reload_q;
  // A button that was high when reset was applied must be seen low once
  // before any of its rising edges are honoured; otherwise a button held
  // through reset would fire as soon as reset drops (the *_q copies are
  // cleared by reset).
  logic          r_fire_arm;
  logic          r_reload_arm;

  state_t        w_state_next;
  logic [TW-1:0] w_timer_next;
  logic [2:0]    w_count_next;
  logic          w_fire_next;
  logic          w_fire_edge;
  logic          w_reload_edge;

  assign w_fire_edge   = fire_btn   & ~r_fire_q   & r_fire_arm;
  assign w_reload_edge = reload_btn & ~r_reload_q & r_reload_arm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_READY;
      r_timer      <= '0;
      r_count      <= MAX_C;
      r_fire       <= 1'b0;
      r_reloading  <= 1'b0;
      r_fire_q     <= 1'b0;
      r_reload_q   <= 1'b0;
      r_fire_arm   <= ~fire_btn;
      r_reload_arm <= ~reload_btn;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_count      <= w_count_next;
      r_fire       <= w_fire_next;
      r_reloading  <= (w_state_next == ST_RELOAD);
      r_fire_q     <= fire_btn;
      r_reload_q   <= reload_btn;
      r_fire_arm   <= r_fire_arm   | ~fire_btn;
      r_reload_arm <= r_reload_arm | ~reload_btn;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_count_next = r_count;
    w_fire_next  = 1'b0;

    case (r_state)
      ST_READY: begin
        // Fire has priority over a simultaneous reload edge.
        if (w_fire_edge && (r_count != 3'd0)) begin
          w_fire_next  = 1'b1;
          w_count_next = r_count - 3'd1;
          w_timer_next = COOL_T;
          w_state_next = ST_COOLDOWN;
        end else if (w_reload_edge && (r_count < MAX_C)) begin
          w_timer_next = REL_T;
          w_state_next = ST_RELOAD;
        end
      end

      ST_COOLDOWN: begin
        if (frame_tick) begin
          if (r_timer <= ONE_T) begin
            // An empty magazine starts reloading on its own.
            if (r_count == 3'd0) begin
              w_timer_next = REL_T;
              w_state_next = ST_RELOAD;
            end else begin
              w_timer_next = '0;
              w_state_next = ST_READY;
            end
          end else begin
            w_timer_next = r_timer - ONE_T;
          end
        end
      end

      ST_RELOAD: begin
        // A shot cancels the reload and wins over a same-cycle tick;
        // rounds already restored stay in the magazine.
        if (w_fire_edge && (r_count != 3'd0)) begin
          w_fire_next  = 1'b1;
          w_count_next = r_count - 3'd1;
          w_timer_next = COOL_T;
          w_state_next = ST_COOLDOWN;
        end else if (frame_tick) begin
          if (r_timer <= ONE_T) begin
            if (r_count < MAX_C) begin
              w_count_next = r_count + 3'd1;
            end
            if ((r_count + 3'd1) >= MAX_C) begin
              w_timer_next = '0;
              w_state_next = ST_READY;
            end else begin
              w_timer_next = REL_T;
            end
          end else begin
            w_timer_next = r_timer - ONE_T;
          end
        end
      end

      default: begin
        w_timer_next = '0;
        w_state_next = ST_READY;
      end
    endcase
  end

  assign count     = r_count;
  assign fire      = r_fire;
  assign reloading = r_reloading;

endmodule
